// File: rtl/fp_add_post_normalizer.sv
// Single-precision adder back end: adds or subtracts two pre-aligned mantissas, then
// normalizes one bit per cycle and packs an IEEE-754 result with truncation rounding.
module fp_add_post_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [7:0]  exp_in,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    // state | meaning
    // IDLE  | waiting for an operand set, in_ready high
    // ADD   | magnitude add/subtract of captured mantissas
    // NORM  | carry shift, one-bit left shift per cycle, or pack
    // DONE  | result presented until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic        sign_a_r;
    logic        sign_b_r;
    logic [7:0]  exp_r;
    logic [23:0] mant_a_r;
    logic [23:0] mant_b_r;
    logic [24:0] sum_r;
    logic        sign_r;
    logic [31:0] result_r;
    logic        out_valid_r;

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            exp_r       <= 8'h00;
            mant_a_r    <= 24'h0;
            mant_b_r    <= 24'h0;
            sum_r       <= 25'h0;
            sign_r      <= 1'b0;
            result_r    <= 32'h0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_a_r <= sign_a;
                        sign_b_r <= sign_b;
                        exp_r    <= exp_in;
                        mant_a_r <= mant_a;
                        mant_b_r <= mant_b;
                        state    <= ADD;
                    end
                end

                ADD: begin
                    if (exp_r == 8'hFF) begin
                        // Infinity/NaN exponent: skip arithmetic, emit signed infinity.
                        result_r    <= {sign_a_r, 8'hFF, 23'h0};
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        if (sign_a_r == sign_b_r) begin
                            sum_r  <= {1'b0, mant_a_r} + {1'b0, mant_b_r};
                            sign_r <= sign_a_r;
                        end else if (mant_a_r > mant_b_r) begin
                            sum_r  <= {1'b0, mant_a_r - mant_b_r};
                            sign_r <= sign_a_r;
                        end else if (mant_b_r > mant_a_r) begin
                            sum_r  <= {1'b0, mant_b_r - mant_a_r};
                            sign_r <= sign_b_r;
                        end else begin
                            sum_r  <= 25'h0;
                            sign_r <= 1'b0;
                        end
                        state <= NORM;
                    end
                end

                NORM: begin
                    if (sum_r == 25'h0) begin
                        result_r    <= 32'h0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (sum_r[24]) begin
                        // Carry out: drop the LSB and bump the exponent, saturating to infinity.
                        if (exp_r == 8'hFE) begin
                            result_r <= {sign_r, 8'hFF, 23'h0};
                        end else begin
                            result_r <= {sign_r, exp_r + 8'd1, sum_r[23:1]};
                        end
                        exp_r       <= exp_r + 8'd1;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (!sum_r[23]) begin
                        if (exp_r > 8'd1) begin
                            sum_r <= {sum_r[23:0], 1'b0};
                            exp_r <= exp_r - 8'd1;
                        end else begin
                            result_r    <= {sign_r, 8'h00, sum_r[22:0]};
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end else begin
                        result_r    <= {sign_r, exp_r, sum_r[22:0]};
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
